instr_fetch_unit: RTL

// - Fetch stage of the MIPS core: owns the PC, runs a req/ack handshake with instruction memory, holds the fetched word.
// - Exposes instr[15:0] to sign_extend and takes its 32-bit result back to form the branch target.
// - Computes next PC: sequential, branch, jump or jump-register; advances one instruction per retire pulse.

---
 rtl/instr_fetch_unit_pkg.sv | 20 ++
 rtl/instr_fetch_unit_pc_next_sel.sv | 35 +++
 rtl/instr_fetch_unit.sv | 100 ++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding, reset PC
// default and instruction field offsets.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  // instruction field offsets
  localparam int IMM_LSB    = 0;
  localparam int IMM_MSB    = 15;
  localparam int TARGET_MSB = 25;

  localparam int TCNT_W = 8;  // holds TIMEOUT_CYC up to 255

endpackage

// File: rtl/instr_fetch_unit_pc_next_sel.sv
// Next-PC priority mux.
//   pc_plus4     : sequential address, also upper bits for J-type targets
//   jtarget      : instr[25:0] J-type target field
//   imm_sext     : sign-extended branch immediate (word offset)
//   branch_taken, jump, jump_reg : redirect selects, jump_reg highest
//   reg_target   : rs value for JR/JALR, used unaligned as-is
//   next_pc      : selected address, all arithmetic mod 2^32
module instr_fetch_unit_pc_next_sel
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0]         pc_plus4,
  input  logic [TARGET_MSB:0] jtarget,
  input  logic [31:0]         imm_sext,
  input  logic                branch_taken,
  input  logic                jump,
  input  logic                jump_reg,
  input  logic [31:0]         reg_target,
  output logic [31:0]         next_pc
);

  logic [31:0] br_target;
  logic [31:0] j_target;

  // shift drops imm_sext[31:30]; the add wraps on overflow
  assign br_target = pc_plus4 + (imm_sext << 2);
  assign j_target  = {pc_plus4[31:28], jtarget, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump_reg)          next_pc = reg_target;
    else if (jump)         next_pc = j_target;
    else if (branch_taken) next_pc = br_target;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, runs the imem req/ack handshake, holds the
// fetched instruction until the core retires it, then steps the PC.
//   clk, rst_n        : clock, async active-low reset
//   imem_req/addr     : fetch request, address = pc, held until ack
//   imem_ack/rdata    : memory response, only honoured in FETCH
//   instr/instr_valid : latched instruction for decode/execute
//   immediate/imm_sext: instr[15:0] out to sign_extend, result back in
//   retire + branch_taken/jump/jump_reg/reg_target : redirect controls
//   pc, pc_plus4      : current address and link value
//   fetch_err         : sticky fetch timeout flag
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [15:0] immediate,
  input  logic [31:0] imm_sext,
  input  logic        retire,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  localparam logic [TCNT_W-1:0] TMO = TCNT_W'(TIMEOUT_CYC);

  fetch_state_e      state, state_d;
  logic [TCNT_W-1:0] tcnt;
  logic [31:0]       next_pc;

  // req and valid come straight from state so reset clears them at once
  assign imem_req    = (state == ST_FETCH);
  assign instr_valid = (state == ST_EXEC);
  assign imem_addr   = pc;
  assign pc_plus4    = pc + 32'd4;
  assign immediate   = instr[IMM_MSB:IMM_LSB];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (imem_ack) state_d = ST_EXEC;
      ST_EXEC:  if (retire)   state_d = ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      instr     <= '0;
      tcnt      <= '0;
      fetch_err <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ack) begin
            instr <= imem_rdata;
            tcnt  <= '0;
          end else if (tcnt != TMO) begin
            // saturating wait counter; flag raised on the edge it hits TMO
            tcnt <= tcnt + 1'b1;
            if (tcnt + 1'b1 == TMO) fetch_err <= 1'b1;
          end
        end
        ST_EXEC: if (retire) pc <= next_pc;
        default: ;
      endcase
    end
  end

  instr_fetch_unit_pc_next_sel u_pc_next_sel (
    .pc_plus4     (pc_plus4),
    .jtarget      (instr[TARGET_MSB:0]),
    .imm_sext     (imm_sext),
    .branch_taken (branch_taken),
    .jump         (jump),
    .jump_reg     (jump_reg),
    .reg_target   (reg_target),
    .next_pc      (next_pc)
  );

endmodule
